fixed_divider: RTL
==================

Name: fixed_divider

Overview:
Iterative signed fixed-point divider, C = A / B, in the datapath's 32-bit two's-complement Q15.16 format (bit 31 sign, bits 30:16 integer, bits 15:0 fraction).
It is the inverse arithmetic unit to the combinational multiplier. It serves AM demodulator stages that need normalisation or gain division.
It uses restoring division, one quotient bit per clock, with a start/done handshake.

Parameters:
WIDTH, 32, total word width including sign bit
FRAC, 16, number of fractional bits

Ports:
clk  input  1  system clock
rst_n  input  1  reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  dividend, Q15.16 two's complement
B  input  WIDTH  divisor, Q15.16 two's complement
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when C is valid
C  output  WIDTH  quotient, held until the next done
div_zero  output  1  B magnitude was zero; valid with done, held
ovf  output  1  quotient magnitude saturated; valid with done, held

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, C=0, div_zero=0, ovf=0, state=IDLE. Reset in any state aborts the operation immediately, and no done pulse follows.
- Magnitude rule: mag(X) = bits [30:0] of (X[31] ? ~X+1 : X).
  - 0x80000000 therefore has magnitude 0; this is intentional and matches the multiplier.
- Sign rule: sign = A[31] ^ B[31].
- FSM state IDLE:
  - On start=1 at edge 0: latch mag(A) shifted left by FRAC (47-bit dividend), mag(B), and sign.
  - Clear the remainder, load the step counter with WIDTH+FRAC-2 (46), set busy=1, go to DIV.
  - start is ignored in every other state.
- FSM state DIV:
  - Each edge performs one restoring step: shift the remainder left by one and bring in the next dividend MSB.
  - If the remainder is >= mag(B), subtract mag(B) and shift quotient bit 1 in; otherwise shift 0 in.
  - When counter==0 go to FIN, otherwise decrement. This gives 47 DIV edges (edges 1..47).
- FSM state FIN (edge 48):
  - Register C, div_zero and ovf; set done=1 and busy=0; go to IDLE.
  - done drops at the next edge.
  - Latency: start sampled at edge 0, done and C visible after edge 48.
- Result selection in FIN, in priority order:
  - mag(B)==0: div_zero=1, ovf=0, C = sign-saturated value. The DIV cycles still run; the result is discarded.
  - mag(A)==0: C=0, flags 0. Sign is ignored, so there is no negative zero.
  - Quotient bits [46:31] nonzero: ovf=1, C = sign-saturated value.
  - Otherwise: q = quotient[30:0], truncated toward zero. C = sign ? {1, ~q+1} : {0, q}. If q==0, C=0.
- Saturated values:
  - Positive: 0x7FFFFFFF.
  - Negative: 0x80000001 (symmetric; 0x80000000 is never produced).
- Flags are rewritten at every FIN.
- Back-to-back: start may be asserted in the cycle done is high. The FSM is in IDLE then and accepts it.

Decomposition:
- Shared package holds:
  - WIDTH and FRAC constants
  - state enum {IDLE, DIV, FIN}
  - SAT_POS and SAT_NEG constants
  - a fixed-point word typedef, also used by the multiplier
- One natural sub-module: fxp_abs, combinational, producing mag and the sign bit. It is instanced twice.

Test Plan:
1. Basic quotient and latency: A=0x00030000, B=0x00020000, start pulse → busy high edges 1..48, done after edge 48, C=0x00018000 (1.5), div_zero=0, ovf=0.
2. Negative dividend: A=0xFFFD0000, B=0x00020000 → C=0xFFFE8000 (-1.5). Then A=0x00030000, B=0xFFFE0000 → same C.
3. Truncation and zero: A=0x00010000, B=0x00030000 → C=0x00005555. A=0x00000000, B=0xFFFF0000 → C=0x00000000.
4. Divide by zero: A=0x00010000, B=0 → div_zero=1, C=0x7FFFFFFF. A=0xFFFF0000, B=0 → C=0x80000001.
5. Overflow: A=0x7FFF0000, B=0x00000100 → ovf=1, C=0x7FFFFFFF. The next normal division clears ovf.
6. Control corners:
   - start pulses at edges 5 and 30 during busy are ignored; a single done follows.
   - rst_n low at edge 20 → busy=0, C=0, no done pulse.
   - start asserted during the done cycle → new result 48 edges later.

Source files
------------

// File: rtl/fixed_divider_pkg.sv
`default_nettype none
// ============================================================================
// fixed_divider_pkg : shared Q15.16 constants, word type and divider states
// Rev 1.0
// ============================================================================
package fixed_divider_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int MAG_W = WIDTH - 1;
    localparam int DVD_W = WIDTH + FRAC - 1;
    localparam int CNT_W = 6;

    typedef logic [WIDTH-1:0] fxp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    localparam fxp_t             SAT_POS   = 32'h7FFF_FFFF;
    localparam fxp_t             SAT_NEG   = 32'h8000_0001;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DVD_W - 1);

endpackage : fixed_divider_pkg
`default_nettype wire

// File: rtl/fixed_divider_if.sv
`default_nettype none
// ============================================================================
// fixed_divider_if : start/done request and result bundle for fixed_divider
// Rev 1.0
// ============================================================================
interface fixed_divider_if;
    import fixed_divider_pkg::*;

    logic start;
    fxp_t A;
    fxp_t B;
    logic busy;
    logic done;
    fxp_t C;
    logic div_zero;
    logic ovf;

    modport master (
        output start, A, B,
        input  busy, done, C, div_zero, ovf
    );

    modport slave (
        input  start, A, B,
        output busy, done, C, div_zero, ovf
    );

endinterface : fixed_divider_if
`default_nettype wire

// File: rtl/fixed_divider_fxp_abs.sv
`default_nettype none
// ============================================================================
// fxp_abs : magnitude and sign of a Q15.16 word (0x80000000 maps to 0)
// Rev 1.0
// ============================================================================
module fxp_abs
    import fixed_divider_pkg::*;
(
    input  wire fxp_t             i_x,
    output logic [MAG_W-1:0]      o_mag,
    output logic                  o_sign
);

    // Only the low bits of the negation are kept, so the most negative
    // word folds onto zero magnitude.
    assign o_mag  = i_x[WIDTH-1] ? (~i_x[MAG_W-1:0] + MAG_W'(1)) : i_x[MAG_W-1:0];
    assign o_sign = i_x[WIDTH-1];

endmodule : fxp_abs
`default_nettype wire

// File: rtl/fixed_divider.sv
`default_nettype none
// ============================================================================
// fixed_divider : iterative restoring signed Q15.16 divider, C = A / B
// Rev 1.0
// ============================================================================
module fixed_divider
    import fixed_divider_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,
    fixed_divider_if.slave   bus
);

    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;
    logic             w_sign_a;
    logic             w_sign_b;

    fxp_abs u_abs_a (
        .i_x    (bus.A),
        .o_mag  (w_mag_a),
        .o_sign (w_sign_a)
    );

    fxp_abs u_abs_b (
        .i_x    (bus.B),
        .o_mag  (w_mag_b),
        .o_sign (w_sign_b)
    );

    div_state_t        r_state;
    logic [DVD_W-1:0]  r_dvd;
    logic [DVD_W-1:0]  r_quo;
    logic [MAG_W-1:0]  r_rem;
    logic [MAG_W-1:0]  r_mag_b;
    logic              r_a_zero;
    logic              r_sign;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    fxp_t              r_c;
    logic              r_div_zero;
    logic              r_ovf;

    logic [MAG_W:0]    w_rem_sh;
    logic              w_ge;
    logic [MAG_W-1:0]  w_diff;
    logic [MAG_W-1:0]  w_q_low;
    logic [MAG_W-1:0]  w_q_neg;
    fxp_t              w_sat;
    fxp_t              w_c;
    logic              w_dz;
    logic              w_ov;

    // The remainder stays below mag(B) < 2^31, so a 31-bit difference is exact.
    assign w_rem_sh = {r_rem, r_dvd[DVD_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_diff   = w_rem_sh[MAG_W-1:0] - r_mag_b;

    assign w_q_low  = r_quo[MAG_W-1:0];
    assign w_q_neg  = ~w_q_low + MAG_W'(1);
    assign w_sat    = r_sign ? SAT_NEG : SAT_POS;

    always_comb begin
        w_c  = '0;
        w_dz = 1'b0;
        w_ov = 1'b0;
        if (r_mag_b == '0) begin
            w_dz = 1'b1;
            w_c  = w_sat;
        end else if (r_a_zero) begin
            w_c  = '0;
        end else if (|r_quo[DVD_W-1:MAG_W]) begin
            w_ov = 1'b1;
            w_c  = w_sat;
        end else if (w_q_low == '0) begin
            w_c  = '0;
        end else if (r_sign) begin
            w_c  = {1'b1, w_q_neg};
        end else begin
            w_c  = {1'b0, w_q_low};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dvd      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_mag_b    <= '0;
            r_a_zero   <= 1'b0;
            r_sign     <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_c        <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd    <= {w_mag_a, {FRAC{1'b0}}};
                        r_mag_b  <= w_mag_b;
                        r_a_zero <= (w_mag_a == '0);
                        r_sign   <= w_sign_a ^ w_sign_b;
                        r_rem    <= '0;
                        r_quo    <= '0;
                        r_cnt    <= CNT_START;
                        r_busy   <= 1'b1;
                        r_state  <= DIV;
                    end
                end
                DIV: begin
                    r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
                    r_rem <= w_ge ? w_diff : w_rem_sh[MAG_W-1:0];
                    r_quo <= {r_quo[DVD_W-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= FIN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIN: begin
                    r_c        <= w_c;
                    r_div_zero <= w_dz;
                    r_ovf      <= w_ov;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.C        = r_c;
    assign bus.div_zero = r_div_zero;
    assign bus.ovf      = r_ovf;

endmodule : fixed_divider
`default_nettype wire
